// File: rtl/depuncture.sv
// Depuncturer: re-inserts punctured positions for 802.11 rates 1/2, 2/3 and 3/4 into rate-1/2 pairs.
// Define DEPUNCTURE_ERASE_EN to add the m_axis_terase erasure-mask output.
module depuncture #(
  parameter int WIDTH = 24
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [2*WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]         s_axis_tuser,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [2*WIDTH-1:0] m_axis_tdata,
`ifdef DEPUNCTURE_ERASE_EN
  output logic [2*WIDTH-1:0] m_axis_terase,
`endif
  output logic [3:0]         m_axis_tuser,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               err
);

  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

`ifdef DEPUNCTURE_ERASE_EN
  localparam int PW = 4*WIDTH + 5;
`else
  localparam int PW = 2*WIDTH + 5;
`endif

  typedef enum logic [1:0] {CLS_12 = 2'd0, CLS_23 = 2'd1, CLS_34 = 2'd2, CLS_BAD = 2'd3} cls_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BODY = 2'd1, ST_DROP = 2'd2} state_t;

  function automatic cls_t f_class(input logic [3:0] rate);
    case (rate)
      RATE_6M, RATE_12M, RATE_24M:           f_class = CLS_12;
      RATE_48M:                              f_class = CLS_23;
      RATE_9M, RATE_18M, RATE_36M, RATE_54M: f_class = CLS_34;
      default:                               f_class = CLS_BAD;
    endcase
  endfunction

  // Each pattern period starts at a fixed input/output bit offset because WIDTH is a multiple of 6.
  function automatic logic [2*WIDTH-1:0] f_depunct(input cls_t cls, input logic [2*WIDTH-1:0] d);
    logic [2*WIDTH-1:0] o;
    o = '0;
    case (cls)
      CLS_23: begin
        for (int p = 0; p < WIDTH/2; p++) begin
          o[4*p]   = d[3*p];
          o[4*p+1] = d[3*p+1];
          o[4*p+2] = d[3*p+2];
        end
      end
      CLS_34: begin
        for (int p = 0; p < WIDTH/3; p++) begin
          o[6*p]   = d[4*p];
          o[6*p+1] = d[4*p+1];
          o[6*p+2] = d[4*p+2];
          o[6*p+5] = d[4*p+3];
        end
      end
      default: o = d;
    endcase
    return o;
  endfunction

`ifdef DEPUNCTURE_ERASE_EN
  function automatic logic [2*WIDTH-1:0] f_erase(input cls_t cls);
    logic [2*WIDTH-1:0] e;
    e = '0;
    case (cls)
      CLS_23: begin
        for (int p = 0; p < WIDTH/2; p++) e[4*p+3] = 1'b1;
      end
      CLS_34: begin
        for (int p = 0; p < WIDTH/3; p++) begin
          e[6*p+3] = 1'b1;
          e[6*p+4] = 1'b1;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction
`endif

  state_t          r_state, w_next_state;
  cls_t            r_cls, w_cls, w_in_cls;
  logic [3:0]      r_rate, w_rate;
  logic            w_accept, w_push, w_err, w_latch, w_pop, w_skid_valid_nxt;
  logic            r_ready, r_err, r_out_valid, r_skid_valid;
  logic [PW-1:0]   r_out, r_skid, w_new;
  logic [2*WIDTH-1:0] w_data;

  assign w_accept = s_axis_tvalid & r_ready;
  assign w_in_cls = f_class(s_axis_tuser);
  assign w_pop    = r_out_valid & m_axis_tready;

  // Packet FSM: decides whether the accepted beat is emitted and with which rate.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_err        = 1'b0;
    w_latch      = 1'b0;
    w_rate       = r_rate;
    w_cls        = r_cls;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_in_cls != CLS_BAD) begin
            w_push       = 1'b1;
            w_latch      = 1'b1;
            w_rate       = s_axis_tuser;
            w_cls        = w_in_cls;
            w_next_state = s_axis_tlast ? ST_IDLE : ST_BODY;
          end else begin
            w_err        = 1'b1;
            w_next_state = s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BODY: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_next_state = s_axis_tlast ? ST_IDLE : ST_BODY;
        end else begin
          w_next_state = ST_BODY;
        end
      end
      ST_DROP: begin
        if (w_accept && s_axis_tlast) w_next_state = ST_IDLE;
        else                          w_next_state = ST_DROP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_data = f_depunct(w_cls, s_axis_tdata);
`ifdef DEPUNCTURE_ERASE_EN
  assign w_new = {s_axis_tlast, w_rate, f_erase(w_cls), w_data};
`else
  assign w_new = {s_axis_tlast, w_rate, w_data};
`endif

  // FSM state, latched packet rate and error pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_rate  <= 4'd0;
      r_cls   <= CLS_12;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_err;
      if (w_latch) begin
        r_rate <= w_rate;
        r_cls  <= w_cls;
      end
    end
  end

  // Skid occupancy after this cycle; input ready is its registered complement.
  always_comb begin
    if (!r_out_valid || w_pop) w_skid_valid_nxt = r_skid_valid & w_push;
    else                       w_skid_valid_nxt = r_skid_valid | w_push;
  end

  // Output register plus one skid entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_ready      <= ~w_skid_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (!r_out_valid || w_pop) begin
        if (r_skid_valid) begin
          r_out       <= r_skid;
          r_out_valid <= 1'b1;
          if (w_push) r_skid <= w_new;
        end else begin
          r_out_valid <= w_push;
          if (w_push) r_out <= w_new;
        end
      end else if (w_push) begin
        r_skid <= w_new;
      end
    end
  end

  assign s_axis_tready = r_ready;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out[2*WIDTH-1:0];
  assign m_axis_tuser  = r_out[PW-2 -: 4];
  assign m_axis_tlast  = r_out[PW-1];
`ifdef DEPUNCTURE_ERASE_EN
  assign m_axis_terase = r_out[4*WIDTH-1:2*WIDTH];
`endif
  assign err = r_err;

endmodule

// File: tb/tb_depuncture.sv
// Randomised bench for depuncture, checked against a bit-stream reference model and a scoreboard.
module tb_depuncture;
  localparam int W  = 24;
  localparam int DW = 2*W;

  localparam logic [3:0] R6  = 4'b1011;
  localparam logic [3:0] R9  = 4'b1111;
  localparam logic [3:0] R12 = 4'b1010;
  localparam logic [3:0] R18 = 4'b1110;
  localparam logic [3:0] R24 = 4'b1001;
  localparam logic [3:0] R36 = 4'b1101;
  localparam logic [3:0] R48 = 4'b1000;
  localparam logic [3:0] R54 = 4'b1100;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [3:0]    s_tuser = 4'd0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
`ifdef DEPUNCTURE_ERASE_EN
  logic [DW-1:0] m_terase;
`endif
  logic [3:0]    m_tuser;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          err;

  depuncture #(.WIDTH(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata),
`ifdef DEPUNCTURE_ERASE_EN
    .m_axis_terase(m_terase),
`endif
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] erase;
    logic [3:0]    user;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   err_due = -10;
  bit   ready_mode = 1'b0;
  bit   ready_hold = 1'b1;
  bit   m_mid = 1'b0;
  bit   m_bad = 1'b0;
  logic [3:0] m_rate = 4'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit supported(input logic [3:0] r);
    return r inside {R6, R9, R12, R18, R24, R36, R48, R54};
  endfunction

  // Walk the output positions; each transmitted position consumes the next input bit.
  function automatic void model(input logic [3:0] rate, input logic [DW-1:0] din,
                                output logic [DW-1:0] d, output logic [DW-1:0] e);
    int plen;
    int k;
    logic [5:0] keep;
    k = 0; d = '0; e = '0;
    if (rate inside {R6, R12, R24}) begin plen = 2; keep = 6'b000011; end
    else if (rate == R48)           begin plen = 4; keep = 6'b000111; end
    else                            begin plen = 6; keep = 6'b100111; end
    for (int i = 0; i < DW; i++) begin
      if (keep[i % plen]) begin d[i] = din[k]; k++; end
      else e[i] = 1'b1;
    end
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #3;
    m_tready = ready_mode ? ($urandom_range(0, 1) == 1) : ready_hold;
  end

  task automatic drive(input logic [DW-1:0] din, input logic [3:0] user, input logic last,
                       input bit use_x, input logic [DW-1:0] xd, input logic [DW-1:0] xe);
    int t;
    bit emit;
    exp_t x;
    @(negedge aclk);
    s_tdata = din; s_tuser = user; s_tlast = last; s_tvalid = 1'b1;
    t = 0;
    while (!s_tready && t < 1000) begin @(negedge aclk); t++; end
    if (!s_tready) begin
      check("accept_timeout", 64'd0, 64'd1);
      s_tvalid = 1'b0;
      return;
    end
    emit = 1'b0;
    if (!m_mid) begin
      m_mid = !last;
      if (supported(user)) begin m_rate = user; m_bad = 1'b0; emit = 1'b1; end
      else begin m_bad = 1'b1; err_due = cyc + 1; end
    end else begin
      emit = !m_bad;
      if (last) m_mid = 1'b0;
    end
    if (emit) begin
      if (use_x) begin x.data = xd; x.erase = xe; end
      else model(m_rate, din, x.data, x.erase);
      x.user = m_rate; x.last = last;
      sb.push_back(x);
    end
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] din, input logic [3:0] user, input logic last);
    drive(din, user, last, 1'b0, '0, '0);
  endtask

  task automatic set_ready(input bit v);
    ready_hold = v;
    @(posedge aclk);
    #4;
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom, $urandom});
  endfunction

  // Output monitor: scoreboard compare, hold-while-stalled, and per-cycle err pulse.
  logic          stall_prev = 1'b0;
  logic [DW+4:0] prev_out = '0;
  always @(negedge aclk) begin
    exp_t x;
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      check("err", {63'd0, err}, {63'd0, cyc == err_due});
      if (stall_prev) begin
        check("stall_valid", {63'd0, m_tvalid}, 64'd1);
        check("stall_payload", {11'd0, m_tdata, m_tuser, m_tlast}, {11'd0, prev_out});
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          x = sb.pop_front();
          check("tdata", {16'd0, m_tdata}, {16'd0, x.data});
          check("tuser", {60'd0, m_tuser}, {60'd0, x.user});
          check("tlast", {63'd0, m_tlast}, {63'd0, x.last});
`ifdef DEPUNCTURE_ERASE_EN
          check("terase", {16'd0, m_terase}, {16'd0, x.erase});
`endif
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_out   = {m_tdata, m_tuser, m_tlast};
    end
  end

  initial begin
    int t;
    logic [3:0] rates [8];
    rates = '{R6, R9, R12, R18, R24, R36, R48, R54};

    repeat (2) @(negedge aclk);
    check("rst_s_tready", {63'd0, s_tready}, 64'd0);
    check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("rst_m_tdata", {16'd0, m_tdata}, 64'd0);
    check("rst_m_tuser", {60'd0, m_tuser}, 64'd0);
    check("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_s_tready", {63'd0, s_tready}, 64'd1);

    // Directed vectors with constant expectations.
    drive(48'h000e7c40858b, R6, 1'b1, 1'b1, 48'h000e7c40858b, 48'h0);
    @(negedge aclk);
    check("latency_valid", {63'd0, m_tvalid}, 64'd1);
    drive(48'h0000FFFFFFFF, R9, 1'b1, 1'b1, 48'h9E79E79E79E7, 48'h618618618618);
    drive(48'h000000000001, R9, 1'b1, 1'b1, 48'h000000000001, 48'h618618618618);
    drive(48'h000000000008, R9, 1'b1, 1'b1, 48'h000000000020, 48'h618618618618);
    drive(48'h000FFFFFFFFF, R48, 1'b1, 1'b1, 48'h777777777777, 48'h888888888888);

    // Rate held for the whole packet even when tuser changes.
    send(rnd(), R9, 1'b0);
    send(rnd(), R6, 1'b0);
    send(rnd(), R6, 1'b0);
    send(rnd(), R6, 1'b1);
    repeat (3) @(negedge aclk);

    // Backpressure: two words fill the buffer, then input ready drops.
    set_ready(1'b0);
    send(rnd(), R48, 1'b0);
    send(rnd(), R48, 1'b0);
    @(negedge aclk);
    check("full_s_tready", {63'd0, s_tready}, 64'd0);
    repeat (3) @(posedge aclk);
    set_ready(1'b1);
    send(rnd(), R48, 1'b1);
    repeat (3) @(negedge aclk);

    // Unsupported rate: packet dropped, one err pulse; next packet normal.
    send(rnd(), 4'b0000, 1'b0);
    send(rnd(), R6, 1'b0);
    send(rnd(), R9, 1'b1);
    send(rnd(), R6, 1'b1);
    repeat (3) @(negedge aclk);

    // Reset mid-packet with two words buffered.
    set_ready(1'b0);
    send(rnd(), R9, 1'b0);
    send(rnd(), R9, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("mid_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("mid_rst_s_tready", {63'd0, s_tready}, 64'd0);
    check("mid_rst_m_tdata", {16'd0, m_tdata}, 64'd0);
    sb.delete();
    m_mid = 1'b0; m_bad = 1'b0;
    ready_hold = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
    send(rnd(), R48, 1'b0);
    send(rnd(), R9, 1'b1);

    // Random packets under random backpressure.
    ready_mode = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int len;
      logic [3:0] r;
      len = $urandom_range(1, 6);
      r = ($urandom_range(0, 9) == 0) ? 4'(2 * $urandom_range(0, 3)) : rates[$urandom_range(0, 7)];
      for (int b = 0; b < len; b++) begin
        send(rnd(), (b == 0) ? r : 4'($urandom), b == len - 1);
      end
    end
    ready_mode = 1'b0;
    ready_hold = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 500) begin @(negedge aclk); t++; end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge aclk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
